// File: rtl/pcie_tx_pkg.sv
// pcie_tx_pkg: shared TLP type codes, arbiter state encoding and credit field layout.
package pcie_tx_pkg;
    typedef enum logic [1:0] {TLP_P = 2'b00, TLP_NP = 2'b01, TLP_CPL = 2'b10, TLP_RSV = 2'b11} tlp_type_e;
    typedef enum logic [1:0] {ARB_IDLE = 2'b00, ARB_REQ = 2'b01, ARB_XFER = 2'b10} arb_state_e;
    localparam int HDR_INF_BIT = 8;
    localparam int DAT_INF_BIT = 12;
    function automatic logic [1:0] rr_next(input logic [1:0] cur, input int n);
        return (int'(cur) + 1 >= n) ? 2'd0 : cur + 2'd1;
    endfunction
endpackage

// File: rtl/pcie_tx_credit_chk.sv
// pcie_tx_credit_chk: decides whether the advertised VC0 credits cover one requester's TLP.
module pcie_tx_credit_chk
    import pcie_tx_pkg::*;
(
    input  logic [1:0]  i_type,
    input  logic [9:0]  i_dcred,
    input  logic [8:0]  i_ph,
    input  logic [8:0]  i_nph,
    input  logic [8:0]  i_cplh,
    input  logic [12:0] i_pd,
    input  logic [12:0] i_npd,
    input  logic [12:0] i_cpld,
    output logic        o_ok
);
    logic [8:0]  w_hdr;
    logic [12:0] w_dat;
    always_comb begin
        w_hdr = (i_type == TLP_P) ? i_ph : (i_type == TLP_NP) ? i_nph : i_cplh;
        w_dat = (i_type == TLP_P) ? i_pd : (i_type == TLP_NP) ? i_npd : i_cpld;
        o_ok  = (i_type != TLP_RSV)
             && (w_hdr[HDR_INF_BIT] || (w_hdr[HDR_INF_BIT-1:0] != '0))
             && (w_dat[DAT_INF_BIT] || (w_dat[DAT_INF_BIT-1:0] >= {2'b00, i_dcred}));
    end
endmodule

// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: round-robin, credit-aware arbiter muxing N_REQ requesters onto the core's VC0 TX port.
module pcie_tx_arb
    import pcie_tx_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = 16
) (
    input  logic                sys_clk_125,
    input  logic                rstn,
    input  logic                dl_up,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  req_type,
    input  logic [10*N_REQ-1:0] req_dcred,
    output logic [N_REQ-1:0]    gnt,
    input  logic [DW*N_REQ-1:0] src_data,
    input  logic [N_REQ-1:0]    src_st,
    input  logic [N_REQ-1:0]    src_end,
    input  logic [N_REQ-1:0]    src_nlfy,
    input  logic                tx_rdy_vc0,
    input  logic [8:0]          tx_ca_ph_vc0,
    input  logic [8:0]          tx_ca_nph_vc0,
    input  logic [8:0]          tx_ca_cplh_vc0,
    input  logic [12:0]         tx_ca_pd_vc0,
    input  logic [12:0]         tx_ca_npd_vc0,
    input  logic [12:0]         tx_ca_cpld_vc0,
    input  logic                tx_ca_p_recheck_vc0,
    input  logic                tx_ca_cpl_recheck_vc0,
    output logic                tx_req_vc0,
    output logic [DW-1:0]       tx_data_vc0,
    output logic                tx_st_vc0,
    output logic                tx_end_vc0,
    output logic                tx_nlfy_vc0,
    output logic                busy,
    output logic [1:0]          cur_src
);
    arb_state_e       r_state;
    logic [1:0]       r_cur;
    logic [1:0]       r_rr;
    logic             r_tx_req;
    logic [N_REQ-1:0] w_cred_ok;
    logic [N_REQ-1:0] w_elig;
    logic [1:0]       w_pick;
    logic [1:0]       w_cur_type;
    logic             w_cur_ok;
    logic             w_recheck;
    logic             w_xfer;
    logic [DW-1:0]    w_data;
    logic             w_st;
    logic             w_end;
    logic             w_nlfy;

    for (genvar g = 0; g < N_REQ; g++) begin : g_chk
        pcie_tx_credit_chk u_chk (
            .i_type  (req_type[2*g +: 2]),
            .i_dcred (req_dcred[10*g +: 10]),
            .i_ph    (tx_ca_ph_vc0),
            .i_nph   (tx_ca_nph_vc0),
            .i_cplh  (tx_ca_cplh_vc0),
            .i_pd    (tx_ca_pd_vc0),
            .i_npd   (tx_ca_npd_vc0),
            .i_cpld  (tx_ca_cpld_vc0),
            .o_ok    (w_cred_ok[g])
        );
    end

    assign w_elig = req & w_cred_ok;

    // Descending scan so the nearest eligible index at or after r_rr is the last one written.
    always_comb begin
        w_pick     = r_rr;
        w_cur_type = TLP_P;
        w_cur_ok   = 1'b0;
        w_data     = '0;
        w_st       = 1'b0;
        w_end      = 1'b0;
        w_nlfy     = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--)
            for (int j = 0; j < N_REQ; j++)
                if (w_elig[j] && ((int'(r_rr) + k) % N_REQ == j)) w_pick = 2'(j);
        for (int j = 0; j < N_REQ; j++)
            if (r_cur == 2'(j)) begin
                w_cur_type = req_type[2*j +: 2];
                w_cur_ok   = w_cred_ok[j];
                w_data     = src_data[DW*j +: DW];
                w_st       = src_st[j];
                w_end      = src_end[j];
                w_nlfy     = src_nlfy[j];
            end
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < N_REQ; j++)
            gnt[j] = (r_state == ARB_REQ) && tx_rdy_vc0 && dl_up && (r_cur == 2'(j));
    end

    assign w_recheck   = (w_cur_type == TLP_CPL) ? tx_ca_cpl_recheck_vc0 : tx_ca_p_recheck_vc0;
    assign w_xfer      = (r_state == ARB_XFER);
    assign tx_data_vc0 = w_xfer ? w_data : '0;
    assign tx_st_vc0   = w_xfer & w_st;
    assign tx_end_vc0  = w_xfer & w_end;
    assign tx_nlfy_vc0 = w_xfer & w_nlfy;
    assign tx_req_vc0  = r_tx_req;
    assign busy        = (r_state != ARB_IDLE);
    assign cur_src     = r_cur;

    always_ff @(posedge sys_clk_125 or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ARB_IDLE;
            r_cur    <= '0;
            r_rr     <= '0;
            r_tx_req <= 1'b0;
        end else if (!dl_up) begin
            r_state  <= ARB_IDLE;
            r_tx_req <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE:
                    if (|w_elig) begin
                        r_state  <= ARB_REQ;
                        r_cur    <= w_pick;
                        r_tx_req <= 1'b1;
                    end
                ARB_REQ:
                    if (tx_rdy_vc0) begin
                        r_state  <= ARB_XFER;
                        r_tx_req <= 1'b0;
                    end else if (w_recheck && !w_cur_ok) begin
                        r_state  <= ARB_IDLE;
                        r_tx_req <= 1'b0;
                    end
                ARB_XFER:
                    if (w_end || w_nlfy) begin
                        r_state <= ARB_IDLE;
                        r_rr    <= rr_next(r_cur, N_REQ);
                    end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
endmodule
